data_ram_reader: RTL and testbench



---
 rtl/data_ram_pkg.sv | 16 +
 rtl/data_ram_reader_if.sv | 31 +++
 rtl/stream_fifo.sv | 54 +++++
 rtl/data_ram_reader.sv | 157 +++++++++++++++
 tb/tb_data_ram_reader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and sizes for the data_ram port-B streaming reader.
package data_ram_pkg;

    localparam int DATA_RAM_ADDR_W = 17;
    localparam int DATA_RAM_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_e;

    typedef logic [DATA_RAM_DATA_W-1:0] ram_word_t;

endpackage

// File: rtl/data_ram_reader_if.sv
// RAM port-B read bus and downstream word stream of the data_ram reader.
interface data_ram_reader_if
    import data_ram_pkg::*;
#(
    parameter int ADDR_W = DATA_RAM_ADDR_W,
    parameter int DATA_W = DATA_RAM_DATA_W
);

    logic              ram_read_enable;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_read_data;

    // Stream: a word transfers in a cycle where out_valid & out_ready; once
    // out_valid rises, out_valid/out_data/out_last hold until that transfer,
    // and out_valid never depends combinationally on out_ready.
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output ram_read_enable, ram_address, out_valid, out_data, out_last,
        input  ram_read_data, out_ready
    );

    modport slave (
        input  ram_read_enable, ram_address, out_valid, out_data, out_last,
        output ram_read_data, out_ready
    );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered storage; push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module stream_fifo #(
    parameter  int WIDTH = 25,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage is reset too so the head word reads as zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/data_ram_reader.sv
// Streaming read engine on data_ram port B: windowed sequential reads into a
// credit-guarded FIFO feeding a valid/ready stream. Optional DATA_RAM_READER_CNT_EN adds beat_count.
module data_ram_reader
    import data_ram_pkg::*;
#(
    parameter int ADDR_W     = DATA_RAM_ADDR_W,
    parameter int DATA_W     = DATA_RAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output reader_state_e     dbg_state,
`ifdef DATA_RAM_READER_CNT_EN
    output logic [ADDR_W:0]   beat_count,
`endif
    data_ram_reader_if.master bus
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    reader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_last_q, rd_last_d;
    logic              ret_q, ret_last_q;

    logic [DATA_W:0]   head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop, push;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;

    // A read decided now lands in the FIFO two cycles later; counting the
    // read on the bus and the word returning keeps a slot for every one.
    assign credit_used = {1'b0, fifo_count}
                       + {{CNT_W{1'b0}}, rd_en_q}
                       + {{CNT_W{1'b0}}, ret_q};
    assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = ret_q & (~fifo_full | pop);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        rd_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        rd_en_d   = 1'b1;
                        addr_d    = base_addr;
                        rd_last_d = (length == LEN_W'(1));
                        issued_d  = LEN_W'(1);
                    end
                end
            end
            RUN: begin
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    rd_en_d   = 1'b1;
                    addr_d    = base_q + issued_q[ADDR_W-1:0];
                    rd_last_d = (issued_q == len_q - LEN_W'(1));
                    issued_d  = issued_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (pop && head[DATA_W]) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_last_q  <= 1'b0;
            ret_q      <= 1'b0;
            ret_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            rd_last_q  <= rd_last_d;
            ret_q      <= rd_en_q;
            ret_last_q <= rd_last_q;
        end
    end

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({ret_last_q, bus.ram_read_data}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.ram_read_enable = rd_en_q;
    assign bus.ram_address     = addr_q;
    assign bus.out_valid       = ~fifo_empty;
    assign bus.out_data        = head[DATA_W-1:0];
    assign bus.out_last        = ~fifo_empty & head[DATA_W];

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

`ifdef DATA_RAM_READER_CNT_EN
    logic [ADDR_W:0] beat_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       beat_q <= '0;
        else if (state_q == IDLE && start) beat_q <= '0;
        else if (pop)                     beat_q <= beat_q + LEN_W'(1);
    end

    assign beat_count = beat_q;
`endif

endmodule

// File: tb/tb_data_ram_reader.sv
// Directed bench for data_ram_reader: RAM model returns data = address.
module tb_data_ram_reader;
  import data_ram_pkg::*;

  localparam int ADDR_W = DATA_RAM_ADDR_W;
  localparam int DATA_W = DATA_RAM_DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  reader_state_e     dbg_state;
`ifdef DATA_RAM_READER_CNT_EN
  logic [ADDR_W:0]   beat_count;
`endif

  data_ram_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_ram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
`ifdef DATA_RAM_READER_CNT_EN
    .beat_count(beat_count),
`endif
    .bus       (bus)
  );

  // one-cycle-latency RAM, contents = address
  always @(posedge clk)
    if (bus.ram_read_enable) bus.ram_read_data <= ram_word_t'(bus.ram_address);

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DATA_W:0]   exp_q[$];
  int                rd_cyc_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                hs_cyc_q[$];
  int                done_cyc_q[$];
  int                valid_cnt;
  int                t0;
  int                mon_rel;
  bit                mon_en = 1'b0;
  logic              busy1;
  logic              pv, pr, pl;
  logic [DATA_W-1:0] pd;
  logic [DATA_W:0]   e;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_rel = cyc - t0;
      if (mon_rel == 1) busy1 = busy;
      if (bus.ram_read_enable) begin
        rd_cyc_q.push_back(mon_rel);
        rd_addr_q.push_back(bus.ram_address);
      end
      if (bus.out_valid) valid_cnt++;
      if (pv && !pr) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(pd));
        check("hold_last", 32'(bus.out_last), 32'(pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc_q.push_back(mon_rel);
        if (exp_q.size() == 0) check("spurious_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e[DATA_W-1:0]));
          check("out_last", 32'(bus.out_last), 32'(e[DATA_W]));
        end
      end
      if (done) done_cyc_q.push_back(mon_rel);
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pl = bus.out_last;
    end else begin
      pv = 1'b0;
      pr = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    hs_cyc_q.delete();
    done_cyc_q.delete();
    valid_cnt = 0;
    busy1 = 1'b0;
  endtask

  // ready is low for relative cycles lo..hi; a stray start fires at restart_at
  task automatic run_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                         input int lo, input int hi, input int restart_at);
    logic [ADDR_W-1:0] a;
    clear_logs();
    for (int i = 0; i < int'(n); i++) begin
      a = b + ADDR_W'(i);
      exp_q.push_back({(i == int'(n) - 1), ram_word_t'(a)});
    end
    t0 = cyc;
    mon_en = 1'b1;
    start = 1'b1;
    base_addr = b;
    length = n;
    bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    while (done_cyc_q.size() == 0 && (cyc - t0) < 400) begin
      bus.out_ready = !((cyc - t0) >= lo && (cyc - t0) <= hi);
      start = ((cyc - t0) == restart_at);
      if (start) begin
        base_addr = 17'h05000;
        length = 18'd2;
      end
      tick();
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    mon_en = 1'b0;
    check("done_count", 32'(done_cyc_q.size()), 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("read_count", 32'(rd_addr_q.size()), 32'(n));
    check("busy_after_start", 32'(busy1), (n != 0) ? 32'd1 : 32'd0);
    foreach (rd_addr_q[i]) begin
      a = b + ADDR_W'(i);
      check("rd_addr", 32'(rd_addr_q[i]), 32'(a));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rden"}, 32'(bus.ram_read_enable), 32'd0);
    check({tag, "_addr"}, 32'(bus.ram_address), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- test sequence ----------------
  int n_early;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: plain 4-word window, exact cycle timing
    run_cmd(17'h00010, 18'd4, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_cycle", 32'(rd_cyc_q[i]), 32'(i + 1));
      check("t1_hs_cycle", 32'(hs_cyc_q[i]), 32'(i + 3));
    end
    check("t1_done_cycle", 32'(done_cyc_q[0]), 32'd7);
`ifdef DATA_RAM_READER_CNT_EN
    check("t1_beat_count", 32'(beat_count), 32'd4);
`endif

    // 2: ready low for cycles 3..8
    run_cmd(17'h00010, 18'd4, 3, 8, -1);
    check("t2_first_hs", 32'(hs_cyc_q[0]), 32'd9);

    // 2b: longer window so the credit limit stalls reads
    run_cmd(17'h00010, 18'd8, 3, 8, -1);
    n_early = 0;
    foreach (rd_cyc_q[i]) if (rd_cyc_q[i] <= 8) n_early++;
    check("t2b_reads_during_stall", 32'(n_early), 32'd4);

    // 3: window wraps past the top address
    run_cmd(17'h1FFFE, 18'd4, -1, -1, -1);

    // 4: zero length
    run_cmd(17'h00123, 18'd0, -1, -1, -1);
    check("t4_done_cycle", 32'(done_cyc_q[0]), 32'd1);
    check("t4_no_valid", 32'(valid_cnt), 32'd0);

    // 5a: start while busy is ignored
    run_cmd(17'h00100, 18'd6, -1, -1, 2);

    // 5b: reset mid-RUN abandons the command
    clear_logs();
    t0 = cyc;
    mon_en = 1'b1;
    start = 1'b1;
    base_addr = 17'h00200;
    length = 18'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    mon_en = 1'b0;
    check("abort_no_done", 32'(done_cyc_q.size()), 32'd0);
    check("abort_no_valid", 32'(valid_cnt), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));

    run_cmd(17'h00040, 18'd5, -1, -1, -1);
`ifdef DATA_RAM_READER_CNT_EN
    check("t5_beat_count", 32'(beat_count), 32'd5);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
